gfx_fill_dma: RTL

Burst-fill controller that loads 32-bit graphics words from external SDRAM into one half of the 512x32 write / 8-bit read graphics line/tile buffer. It accepts a fill request (source address, word count, target bank), issues fixed-length bursts on the memory port and drives the buffer's write port, one word per valid beat. It sits directly upstream of the buffer's write port; the pixel side reads the other bank through the byte port in parallel (ping-pong).

---
 rtl/gfx_fill_pkg.sv | 16 +
 rtl/gfx_fill_dma.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/gfx_fill_pkg.sv
// Shared types and defaults for the graphics burst-fill controller.
// Defines the FSM state encoding and the default memory and buffer geometry.
package gfx_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } fill_state_t;

    localparam int DEF_BURST_LEN = 8;
    localparam int DEF_ADDR_W    = 22;
    localparam int BANK_AW       = 8;

endpackage

// File: rtl/gfx_fill_dma.sv
// Fills one bank of the line/tile buffer from SDRAM in BURST_LEN bursts; buffer write lands 1 cycle after each beat.
// No backpressure on the beat stream. mem_rd is held until mem_ack. GFX_FILL_CHECKSUM_EN adds a fill_sum XOR output.
module gfx_fill_dma
    import gfx_fill_pkg::*;
#(
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_req,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [8:0]        fill_len,
    input  logic              fill_bank,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_vld,
    input  logic [31:0]       mem_data,
    output logic              wr_en,
    output logic [8:0]        wr_addr,
    output logic [31:0]       wr_data
`ifdef GFX_FILL_CHECKSUM_EN
    ,
    output logic [31:0]       fill_sum
`endif
);

    localparam int BW = $clog2(BURST_LEN) + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BURST_LEN - 1);

    fill_state_t         state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [8:0]          rem_q, rem_d;
    logic [BANK_AW-1:0]  idx_q, idx_d;
    logic                bank_q, bank_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic                wr_en_q, wr_en_d;
    logic [8:0]          wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic [31:0]         sum_q, sum_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        bank_d    = bank_q;
        beat_d    = beat_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        sum_d     = sum_q;
        // Completion pulse trails the DONE state by one cycle so busy and done never overlap.
        done_d    = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (fill_req) begin
                    addr_d  = fill_addr & ALIGN_MASK;
                    rem_d   = fill_len;
                    idx_d   = '0;
                    bank_d  = fill_bank;
                    sum_d   = '0;
                    state_d = (fill_len == 9'd0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    beat_d  = BW'(BURST_LEN);
                    state_d = DATA;
                end
            end
            DATA: begin
                if (mem_vld) begin
                    beat_d = beat_q - BW'(1);
                    // Beats past the requested length are the tail of the last burst and are dropped.
                    if (rem_q != 9'd0) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {bank_q, idx_q};
                        wr_data_d = mem_data;
                        idx_d     = idx_q + BANK_AW'(1);
                        rem_d     = rem_q - 9'd1;
                        sum_d     = sum_q ^ mem_data;
                    end
                    if (beat_q == BW'(1)) begin
                        if (rem_d != 9'd0) begin
                            addr_d  = addr_q + ADDR_W'(BURST_LEN);
                            state_d = REQ;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            idx_q     <= '0;
            bank_q    <= 1'b0;
            beat_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            sum_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            bank_q    <= bank_d;
            beat_q    <= beat_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            sum_q     <= sum_d;
        end
    end

    assign fill_busy = (state_q != IDLE);
    assign fill_done = done_q;
    assign mem_rd    = (state_q == REQ);
    assign mem_addr  = addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

`ifdef GFX_FILL_CHECKSUM_EN
    assign fill_sum = sum_q;
`else
    logic unused_sum;
    assign unused_sum = ^sum_q;
`endif

endmodule
